// File: rtl/ddr_pixel_serializer_if.sv
// Pixel word stream into the DDR serializer: valid/ready handshake carrying one word per transfer.
interface ddr_pixel_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ddr_pixel_serializer.sv
// Pixel FIFO plus line controller that feeds an ODDR2 two bits per clock, MSB first.
// Defining DDR_UNDERFLOW_COUNT_EN enables the saturating underflow counter; otherwise it reads 0.
module ddr_pixel_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ddr_pixel_serializer_if.slave pix,
    input  logic                  line_start,
    input  logic [LEN_W-1:0]      line_len,
    output logic                  d0,
    output logic                  d1,
    output logic                  ce,
    output logic                  active,
    output logic [7:0]            underflow_count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int HALF = WIDTH / 2;
    localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [PW-1:0]    LAST_PHASE = PW'(HALF - 1);
    localparam logic [PW-1:0]    PHASE_ONE  = PW'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [AW:0]      CNT_ONE    = (AW + 1)'(1);
    localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;

    state_t           state_r;
    logic [PW-1:0]    phase_r;
    logic [LEN_W-1:0] words_left_r;
    logic [WIDTH-1:0] shifter_r;
    logic             active_r;

    logic             push_s;
    logic             pop_s;
    logic             slot_load_s;
    logic             fifo_empty_s;
    logic [WIDTH-1:0] load_word_s;

    // count_r never exceeds DEPTH, so its top bit alone means "full".
    assign pix.in_ready = ~count_r[AW];
    assign fifo_empty_s = (count_r == {(AW + 1){1'b0}});
    assign push_s       = pix.in_valid & ~count_r[AW];
    assign pop_s        = slot_load_s & ~fifo_empty_s;

    assign d0     = shifter_r[WIDTH-1];
    assign d1     = shifter_r[WIDTH-2];
    assign active = active_r;
    assign ce     = active_r;

    // Decide whether this cycle opens a new word slot.
    always_comb begin
        slot_load_s = 1'b0;
        if (state_r == IDLE) begin
            if (line_start && (line_len != {LEN_W{1'b0}})) begin
                slot_load_s = 1'b1;
            end else begin
                slot_load_s = 1'b0;
            end
        end else begin
            if ((phase_r == LAST_PHASE) && (words_left_r != LEN_ONE)) begin
                slot_load_s = 1'b1;
            end else begin
                slot_load_s = 1'b0;
            end
        end
    end

    // Word presented to the shifter on a slot load; an empty FIFO yields an all-zero underflow slot.
    always_comb begin
        load_word_s = {WIDTH{1'b0}};
        if (fifo_empty_s) begin
            load_word_s = {WIDTH{1'b0}};
        end else begin
            load_word_s = mem_r[rd_ptr_r];
        end
    end

    // FIFO pointers and occupancy; a push is only visible to a pop from the next edge on.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; emptied logically by the pointer reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= pix.in_data;
        end
    end

    // Line controller: slot timing, word countdown and the output shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            phase_r      <= {PW{1'b0}};
            words_left_r <= {LEN_W{1'b0}};
            shifter_r    <= {WIDTH{1'b0}};
            active_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    phase_r <= {PW{1'b0}};
                    if (slot_load_s) begin
                        state_r      <= ACTIVE;
                        active_r     <= 1'b1;
                        words_left_r <= line_len;
                        shifter_r    <= load_word_s;
                    end else begin
                        state_r      <= IDLE;
                        active_r     <= 1'b0;
                        words_left_r <= words_left_r;
                        shifter_r    <= {WIDTH{1'b0}};
                    end
                end
                ACTIVE: begin
                    if (phase_r == LAST_PHASE) begin
                        phase_r      <= {PW{1'b0}};
                        words_left_r <= words_left_r - LEN_ONE;
                        if (words_left_r == LEN_ONE) begin
                            state_r   <= IDLE;
                            active_r  <= 1'b0;
                            shifter_r <= {WIDTH{1'b0}};
                        end else begin
                            state_r   <= ACTIVE;
                            active_r  <= 1'b1;
                            shifter_r <= load_word_s;
                        end
                    end else begin
                        phase_r      <= phase_r + PHASE_ONE;
                        words_left_r <= words_left_r;
                        state_r      <= ACTIVE;
                        active_r     <= 1'b1;
                        shifter_r    <= shifter_r << 2'd2;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    phase_r      <= {PW{1'b0}};
                    words_left_r <= {LEN_W{1'b0}};
                    shifter_r    <= {WIDTH{1'b0}};
                    active_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef DDR_UNDERFLOW_COUNT_EN
    logic       underflow_s;
    logic [7:0] underflow_count_r;

    assign underflow_s     = slot_load_s & fifo_empty_s;
    assign underflow_count = underflow_count_r;

    // Saturating count of slots that found the FIFO empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_count_r <= 8'd0;
        end else begin
            if (underflow_s && (underflow_count_r != 8'hFF)) begin
                underflow_count_r <= underflow_count_r + 8'd1;
            end else begin
                underflow_count_r <= underflow_count_r;
            end
        end
    end
`else
    assign underflow_count = 8'd0;
`endif

endmodule

// File: tb/tb_ddr_pixel_serializer.sv
// Randomized bench for ddr_pixel_serializer against a slot-level reference model.
module tb_ddr_pixel_serializer;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          line_start;
    logic [LW-1:0] line_len;
    logic          d0, d1, ce, active;
    logic [7:0]    underflow_count;

    ddr_pixel_serializer_if #(.WIDTH(W)) pix ();

    ddr_pixel_serializer #(.WIDTH(W), .DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk             (clk),
        .reset           (reset),
        .pix             (pix),
        .line_start      (line_start),
        .line_len        (line_len),
        .d0              (d0),
        .d1              (d1),
        .ce              (ce),
        .active          (active),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending words, current word, bit-pair position and words left in the line.
    logic [W-1:0] m_q[$];
    bit           m_busy;
    int           m_words;
    int           m_pos;
    logic [W-1:0] m_cur;
    int           m_uf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input logic [W-1:0] dat,
                              input bit ls, input logic [LW-1:0] len);
        bit load;
        bit room;
        if (rst) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_words = 0;
            m_pos   = 0;
            m_cur   = '0;
            m_uf    = 0;
            return;
        end
        room = (m_q.size() < DEPTH);
        load = 1'b0;
        if (!m_busy) begin
            if (ls && (len != 0)) begin
                m_busy  = 1'b1;
                m_words = int'(len);
                load    = 1'b1;
            end
        end else begin
            m_pos++;
            if (m_pos == W / 2) begin
                m_words--;
                if (m_words == 0) begin
                    m_busy = 1'b0;
                    m_pos  = 0;
                end else begin
                    load = 1'b1;
                end
            end
        end
        if (load) begin
            m_pos = 0;
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
            end else begin
                m_cur = '0;
                m_uf++;
            end
        end
        // Words arriving this cycle join after the pop, so they never rescue an underflow slot.
        if (v && room) m_q.push_back(dat);
    endtask

    function automatic logic [7:0] exp_ucount();
`ifdef DDR_UNDERFLOW_COUNT_EN
        return (m_uf > 255) ? 8'd255 : 8'(m_uf);
`else
        return 8'd0;
`endif
    endfunction

    // One clock: drive inputs, advance DUT and model on the edge, compare just after it.
    task automatic cycle(input bit rst, input bit v, input logic [W-1:0] dat,
                         input bit ls, input logic [LW-1:0] len);
        logic exp_d0;
        logic exp_d1;
        reset        = rst;
        pix.in_valid = v;
        pix.in_data  = dat;
        line_start   = ls;
        line_len     = len;
        @(posedge clk);
        model_step(rst, v, dat, ls, len);
        #1;
        exp_d0 = m_busy ? m_cur[W-1-2*m_pos] : 1'b0;
        exp_d1 = m_busy ? m_cur[W-2-2*m_pos] : 1'b0;
        check("active", 32'(active), 32'(m_busy));
        check("ce", 32'(ce), 32'(m_busy));
        check("d0", 32'(d0), 32'(exp_d0));
        check("d1", 32'(d1), 32'(exp_d1));
        check("in_ready", 32'(pix.in_ready), 32'(m_q.size() < DEPTH));
        check("underflow_count", 32'(underflow_count), 32'(exp_ucount()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    logic [1:0] pairs [8];

    initial begin
        pairs[0] = 2'b10; pairs[1] = 2'b11; pairs[2] = 2'b01; pairs[3] = 2'b00;
        pairs[4] = 2'b00; pairs[5] = 2'b01; pairs[6] = 2'b11; pairs[7] = 2'b11;

        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        check("reset_active", 32'(active), 32'd0);
        check("reset_ready", 32'(pix.in_ready), 32'd1);

        // Two-word line 0xB4, 0x1F against the literal bit-pair sequence.
        cycle(1'b0, 1'b1, 8'hB4, 1'b0, '0);
        cycle(1'b0, 1'b1, 8'h1F, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, 8'd2);
        check("pair0", 32'({d0, d1}), 32'(pairs[0]));
        for (int i = 1; i < 8; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0, '0);
            check("pair", 32'({d0, d1}), 32'(pairs[i]));
            check("pair_active", 32'(active), 32'd1);
        end
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        check("line_end_active", 32'(active), 32'd0);
        check("line_end_ucount", 32'(underflow_count), 32'd0);

        // Underflow line of 3, then push the counter past saturation.
        cycle(1'b0, 1'b0, '0, 1'b1, 8'd3);
        idle(13);
        for (int l = 0; l < 3; l++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 8'd100);
            idle(400);
        end

        // Back-pressure, then a line drains the full FIFO.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, W'($urandom()), 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, 8'd2);
        idle(9);

        // Ignored starts: zero length while idle, and a pulse mid-line.
        cycle(1'b0, 1'b0, '0, 1'b1, 8'd0);
        idle(2);
        cycle(1'b0, 1'b1, W'($urandom()), 1'b0, '0);
        cycle(1'b0, 1'b1, W'($urandom()), 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, 8'd2);
        idle(2);
        cycle(1'b0, 1'b0, '0, 1'b1, 8'd5);
        idle(8);

        // Reset during word 1 of a 4-word line with two words still queued.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, W'($urandom()), 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, 8'd4);
        idle(4);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, 8'd2);
        idle(9);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 6), W'($urandom()),
                  ($urandom_range(0, 19) == 0), LW'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_pixel_serializer.md
# ddr_pixel_serializer

Converts a stream of pixel words into per-clock bit pairs for a DDR output primitive, two bits per clock, MSB first. Sits directly upstream of the ODDR2 output stage in the Life video path. A small FIFO decouples the pixel fetch logic from the fixed-rate output. A line controller emits exactly `line_len` words per line and counts underflows.

## Interface
- `WIDTH`, default 8: pixel word width; must be even and at least 2.
- `DEPTH`, default 4: FIFO depth in words; must be a power of 2 and at least 2.
- `LEN_W`, default 8: width of `line_len`.
- `clk`  in  1  single clock; also the clock the ODDR2 C0 input uses.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  WIDTH  pixel word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a word.
- `line_start`  in  1  single-cycle strobe that starts a line.
- `line_len`  in  LEN_W  number of words in the line; sampled on `line_start`.
- `d0`  out  1  bit for ODDR2 D0 (first half of the clock).
- `d1`  out  1  bit for ODDR2 D1 (second half of the clock).
- `ce`  out  1  ODDR2 clock enable; equals `active`.
- `active`  out  1  a line is being output.
- `underflow_count`  out  8  saturating count of underflow slots.

## Operation
- The FIFO holds DEPTH words with registered read/write pointers and an occupancy count.
  - `in_ready` = count < DEPTH. It is driven only from registers.
  - A push occurs when `in_valid && in_ready`.
- Shifter: a WIDTH-bit register. `d0` = shifter[WIDTH-1], `d1` = shifter[WIDTH-2].
- States: IDLE and ACTIVE.
  - IDLE:
    - shifter = 0, `active` = 0.
    - When `line_start` is high and `line_len` != 0:
      - go to ACTIVE;
      - load `words_left` = `line_len`;
      - perform a slot load.
    - When `line_start` is high and `line_len` == 0: ignored, stay in IDLE.
  - ACTIVE:
    - The phase counter counts 0..WIDTH/2-1.
    - At phases other than the last, the shifter shifts left by 2 and zero-fills.
    - At the last phase, `words_left` decrements.
      - If the result is 0: go to IDLE and clear the shifter.
      - Otherwise: perform a slot load.
- Slot load:
  - If the FIFO is non-empty: pop the head into the shifter.
  - If the FIFO is empty: load zeros (an underflow slot) and increment `underflow_count`, saturating at 255.
  - The slot still lasts WIDTH/2 cycles, so line timing never stretches.
- Push and pop in the same cycle:
  - Allowed; the count is unchanged.
  - There is no bypass. A word pushed in the same cycle as a slot load into an empty FIFO is not used for that slot. The slot underflows and the word is used by the next slot.
- `line_start` during ACTIVE is ignored.
- The FIFO is not flushed at the end of a line; leftover words feed the next line.

## Timing
- Reset values: `in_ready`=1, `d0`=0, `d1`=0, `ce`=0, `active`=0, `underflow_count`=0.
  - Reset also empties the FIFO, clears the phase counter and `words_left`, and sets the state to IDLE.
- Reset during ACTIVE aborts the line: all of the above hold from the next cycle on.
- Latency: with `line_start` sampled at edge k, `active`, `d0` and `d1` carry word 0's top bits after edge k.
- Each word occupies exactly WIDTH/2 consecutive cycles. A line occupies `line_len`·WIDTH/2 cycles.
- `active` falls on the edge that ends the last slot. The next `line_start` is accepted in that same cycle or any later one.
- A push is visible to a pop on the next edge; `in_ready` reflects a pop on the next cycle.
- All outputs are registered or simple bit-selects of registers. There are no combinational paths from inputs to outputs.

## Configuration
- `DDR_UNDERFLOW_COUNT_EN`:
  - Defined: the underflow counter is implemented as described.
  - Undefined: the counter logic is omitted and `underflow_count` is tied to 0. Underflow slots still output zeros and line timing is unchanged.

## Test plan
- Line of 2 words with WIDTH=8:
  - Stimulus: push 0xB4 and 0x1F, then pulse `line_start` with `line_len`=2.
  - Required: d0/d1 pairs (1,0),(1,1),(0,1),(0,0),(0,0),(0,1),(1,1),(1,1) over 8 cycles. `active` is high for exactly those 8 cycles; then `underflow_count`=0 and `in_ready`=1.
- Underflow, Configuration (macro defined):
  - Stimulus: FIFO empty, `line_len`=3.
  - Required: 12 cycles of d0=d1=0 with `active` high; `underflow_count`=3.
  - Repeat until 300 underflows have occurred: `underflow_count` holds at 255.
- Back-pressure:
  - Stimulus: hold `in_valid`=1 with DEPTH=4 and no line running.
  - Required: after 4 pushes `in_ready`=0. Start a line and `in_ready` returns to 1 the cycle after the first pop.
- Ignored starts:
  - Stimulus: `line_start` with `line_len`=0; separately, `line_start` pulsed mid-line.
  - Required: the first leaves the block in IDLE with `active`=0. The second leaves the output sequence and line length unchanged.
- Reset mid-line:
  - Stimulus: assert `reset` during word 1 of a 4-word line with 2 words still queued.
  - Required: next cycle `active`=0, d0=d1=0, `in_ready`=1. A new line with an empty FIFO underflows on its first slot.
- Configuration (macro undefined): repeat the underflow scenario; required: `underflow_count` stays 0 and the output waveform is unchanged.
